// File: rtl/gauss3x3_filter.sv
`default_nettype none
// ============================================================================
//  Module   : gauss3x3_filter
//  Purpose  : 3x3 Gaussian smoothing of a vs/de/RGB stream, fixed 3-clk delay.
//  Revision : 1.0  initial release
// ============================================================================
module gauss3x3_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int MAX_WIDTH  = 1280,
    parameter int X_WIDTH    = 11,
    parameter int Y_WIDTH    = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           filter_en,
    input  logic                           vs_i,
    input  logic                           de_i,
    input  logic [DATA_WIDTH*CHANNELS-1:0] rgb_i,
    output logic                           vs_o,
    output logic                           de_o,
    output logic [DATA_WIDTH*CHANNELS-1:0] rgb_o
);

    localparam int c_pix_w  = DATA_WIDTH * CHANNELS;
    localparam int c_acc_w  = DATA_WIDTH + 4;
    localparam int c_addr_w = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    logic                 r_vs_d1, r_de_d1, r_vs_d2, r_de_d2;
    logic [X_WIDTH-1:0]   r_x;
    logic [Y_WIDTH-1:0]   r_y;
    logic                 r_en;
    logic [c_pix_w-1:0]   r_pix_d1, r_pix_d2, r_filt_d2;
    logic                 r_byp_d1, r_byp_d2;
    logic                 r_row0_d1, r_row1_d1, r_x0_d1, r_x1_d1;
    logic [2:0][c_pix_w-1:0] r_c1, r_c2;
    logic [c_pix_w-1:0]   r_lb0 [MAX_WIDTH];
    logic [c_pix_w-1:0]   r_lb1 [MAX_WIDTH];
    logic [c_pix_w-1:0]   r_lb0_q, r_lb1_q;

    logic                 w_vs_rise, w_de_fall, w_en, w_in_range, w_ram_en;
    logic                 w_y_zero, w_y_one;
    logic [c_addr_w-1:0]  w_addr;
    logic [2:0][c_pix_w-1:0] w_c0, w_c1, w_c2;
    logic [c_acc_w-1:0]   w_sum [CHANNELS];
    logic [c_pix_w-1:0]   w_filt;

    // A pixel arriving with the vs_i rising edge already belongs to the new frame.
    assign w_vs_rise  = vs_i & ~r_vs_d1;
    assign w_de_fall  = ~de_i & r_de_d1;
    assign w_en       = w_vs_rise ? filter_en : r_en;
    assign w_y_zero   = w_vs_rise | (r_y == '0);
    assign w_y_one    = ~w_vs_rise & (r_y == Y_WIDTH'(1));
    assign w_in_range = ({1'b0, r_x} < (X_WIDTH + 1)'(MAX_WIDTH));
    assign w_ram_en   = de_i & w_in_range;
    assign w_addr     = r_x[c_addr_w-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_en <= 1'b0;
        end else begin
            if (w_vs_rise)
                r_en <= filter_en;
            if (de_i) begin
                if (r_x != '1)
                    r_x <= r_x + X_WIDTH'(1);
            end else begin
                r_x <= '0;
            end
            if (w_vs_rise)
                r_y <= '0;
            else if (w_de_fall && r_y != '1)
                r_y <= r_y + Y_WIDTH'(1);
        end
    end

    // Read-before-write: LB0 returns row y-1, LB1 returns row y-2.
    always_ff @(posedge clk) begin
        if (w_ram_en) begin
            r_lb0_q        <= r_lb0[w_addr];
            r_lb1_q        <= r_lb1[w_addr];
            r_lb0[w_addr]  <= rgb_i;
            r_lb1[w_addr]  <= r_lb0[w_addr];
        end
    end

    // Newest column with top/middle taps clamped to row 0 near the frame top.
    assign w_c0[0] = r_row0_d1 ? r_pix_d1 : (r_row1_d1 ? r_lb0_q : r_lb1_q);
    assign w_c0[1] = r_row0_d1 ? r_pix_d1 : r_lb0_q;
    assign w_c0[2] = r_pix_d1;
    assign w_c1    = r_x0_d1 ? w_c0 : r_c1;
    assign w_c2    = r_x0_d1 ? w_c0 : (r_x1_d1 ? r_c1 : r_c2);

    function automatic logic [c_acc_w-1:0] f_vsum(input logic [2:0][c_pix_w-1:0] col,
                                                   input int ch);
        f_vsum = c_acc_w'(col[0][ch*DATA_WIDTH +: DATA_WIDTH])
               + (c_acc_w'(col[1][ch*DATA_WIDTH +: DATA_WIDTH]) << 1)
               + c_acc_w'(col[2][ch*DATA_WIDTH +: DATA_WIDTH]);
    endfunction

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        assign w_sum[ch] = f_vsum(w_c2, ch) + (f_vsum(w_c1, ch) << 1)
                         + f_vsum(w_c0, ch) + c_acc_w'(8);
        assign w_filt[ch*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum[ch] >> 4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1   <= 1'b0;
            r_de_d1   <= 1'b0;
            r_pix_d1  <= '0;
            r_byp_d1  <= 1'b1;
            r_row0_d1 <= 1'b1;
            r_row1_d1 <= 1'b0;
            r_x0_d1   <= 1'b1;
            r_x1_d1   <= 1'b0;
            r_vs_d2   <= 1'b0;
            r_de_d2   <= 1'b0;
            r_pix_d2  <= '0;
            r_filt_d2 <= '0;
            r_byp_d2  <= 1'b1;
            r_c1      <= '0;
            r_c2      <= '0;
            vs_o      <= 1'b0;
            de_o      <= 1'b0;
            rgb_o     <= '0;
        end else begin
            r_vs_d1   <= vs_i;
            r_de_d1   <= de_i;
            r_pix_d1  <= rgb_i;
            r_byp_d1  <= ~w_en | ~w_in_range;
            r_row0_d1 <= w_y_zero;
            r_row1_d1 <= w_y_one;
            r_x0_d1   <= (r_x == '0);
            r_x1_d1   <= (r_x == X_WIDTH'(1));

            r_vs_d2   <= r_vs_d1;
            r_de_d2   <= r_de_d1;
            r_pix_d2  <= r_pix_d1;
            r_filt_d2 <= w_filt;
            r_byp_d2  <= r_byp_d1;
            r_c1      <= w_c0;
            r_c2      <= r_c1;

            vs_o      <= r_vs_d2;
            de_o      <= r_de_d2;
            if (r_de_d2)
                rgb_o <= r_byp_d2 ? r_pix_d2 : r_filt_d2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gauss3x3_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gauss3x3_filter
//  Purpose  : Self-checking bench for gauss3x3_filter (line buffer depth 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gauss3x3_filter;

    localparam int PW   = 24;
    localparam int MAXW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          filter_en = 1'b0;
    logic          vs_i = 1'b0;
    logic          de_i = 1'b0;
    logic [PW-1:0] rgb_i = '0;
    logic          vs_o, de_o;
    logic [PW-1:0] rgb_o;

    gauss3x3_filter #(
        .DATA_WIDTH (8),
        .CHANNELS   (3),
        .MAX_WIDTH  (MAXW),
        .X_WIDTH    (11),
        .Y_WIDTH    (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .filter_en (filter_en),
        .vs_i      (vs_i),
        .de_i      (de_i),
        .rgb_i     (rgb_i),
        .vs_o      (vs_o),
        .de_o      (de_o),
        .rgb_o     (rgb_o)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [PW-1:0] img     [16][16];
    logic [PW-1:0] out_img [16][16];
    logic [PW-1:0] exp_q[$];
    int            out_cnt = 0;
    int            ox = 0, oy = 0;
    bit            chk_en = 1'b0;
    logic          vs_prev = 1'b0, de_prev = 1'b0;
    logic [2:0]    h_vs = '0, h_de = '0;

    typedef struct {
        int            frame;
        int            x;
        int            y;
        logic [PW-1:0] exp;
    } spot_t;
    spot_t tbl[$];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Spec-level reference: clamped 3x3 kernel centred one row/column back.
    function automatic logic [PW-1:0] ref_pix(input int x, input int y, input bit en);
        logic [PW-1:0] r;
        logic [PW-1:0] p;
        int s, yy, xx;
        r = '0;
        if (!en || x >= MAXW) return img[y][x];
        for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    yy = (y - 1 + dy < 0) ? 0 : y - 1 + dy;
                    xx = (x - 1 + dx < 0) ? 0 : x - 1 + dx;
                    p  = img[yy][xx];
                    s += ((dy == 0) ? 2 : 1) * ((dx == 0) ? 2 : 1) * int'(p[c*8 +: 8]);
                end
            end
            r[c*8 +: 8] = 8'((s + 8) / 16);
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            h_vs = {h_vs[1:0], vs_i};
            h_de = {h_de[1:0], de_i};
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (chk_en)
                    check("vs_o/de_o delay", PW'({vs_o, de_o}), PW'({h_vs[2], h_de[2]}));
                if (vs_o && !vs_prev) begin
                    ox = 0; oy = 0; out_cnt = 0;
                end
                if (de_o) begin
                    if (ox < 16 && oy < 16) out_img[oy][ox] = rgb_o;
                    if (chk_en) begin
                        if (exp_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL rgb_o: got pixel %h, required no pixel", rgb_o);
                        end else begin
                            check($sformatf("rgb_o model x%0d y%0d", ox, oy), rgb_o, exp_q.pop_front());
                        end
                    end
                    ox++; out_cnt++;
                end else if (de_prev) begin
                    oy++; ox = 0;
                end
            end
            vs_prev = vs_o;
            de_prev = de_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int w, input int h, input bit en,
                               input int tog_row, input bit tog_val, input bit vs_with_de);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                out_img[y][x] = '1;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back(ref_pix(x, y, en));
        filter_en = en;
        if (!vs_with_de) begin
            vs_i = 1'b1; tick(); tick();
            vs_i = 1'b0; tick(); tick();
        end
        for (int y = 0; y < h; y++) begin
            if (y == tog_row) filter_en = tog_val;
            for (int x = 0; x < w; x++) begin
                de_i  = 1'b1;
                rgb_i = img[y][x];
                vs_i  = vs_with_de && (y == 0) && (x < 2);
                tick();
            end
            de_i  = 1'b0;
            vs_i  = 1'b0;
            rgb_i = PW'($urandom);
            repeat (4) tick();
        end
        repeat (4) tick();
        check("pixel count", PW'(out_cnt), PW'(w * h));
        check("expected queue drained", PW'(exp_q.size()), '0);
    endtask

    task automatic run_frame(input int id);
        int w = 8, h = 8, tr = -1;
        bit en = 1'b1, tv = 1'b0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = '0;
        case (id)
            0: for (int y = 0; y < 8; y++)
                   for (int x = 0; x < 8; x++)
                       img[y][x] = 24'h808080;
            2: for (int x = 0; x < 8; x++)
                   img[0][x] = 24'hA0A0A0;
            5: begin
                   w = 10; h = 6;
                   for (int y = 0; y < h; y++)
                       for (int x = 0; x < w; x++)
                           img[y][x] = {3{8'(x * 20)}};
               end
            default: begin
                   img[4][4] = 24'hFF0000;
                   if (id == 3) begin en = 1'b0; tr = 3; tv = 1'b1; end
               end
        endcase
        drive_frame(w, h, en, tr, tv, 1'b0);
    endtask

    initial begin
        int cur;
        // frame 0 flat, 1 impulse, 2 top-edge, 3 bypass+toggle, 4 next frame, 5 overrun ramp
        tbl.push_back('{0, 0, 0, 24'h808080});
        tbl.push_back('{0, 7, 7, 24'h808080});
        tbl.push_back('{0, 3, 4, 24'h808080});
        tbl.push_back('{1, 5, 5, 24'h400000});
        tbl.push_back('{1, 4, 5, 24'h200000});
        tbl.push_back('{1, 6, 5, 24'h200000});
        tbl.push_back('{1, 5, 4, 24'h200000});
        tbl.push_back('{1, 5, 6, 24'h200000});
        tbl.push_back('{1, 4, 4, 24'h100000});
        tbl.push_back('{1, 6, 4, 24'h100000});
        tbl.push_back('{1, 4, 6, 24'h100000});
        tbl.push_back('{1, 6, 6, 24'h100000});
        tbl.push_back('{1, 3, 3, 24'h000000});
        tbl.push_back('{1, 7, 7, 24'h000000});
        tbl.push_back('{1, 5, 7, 24'h000000});
        tbl.push_back('{2, 0, 0, 24'hA0A0A0});
        tbl.push_back('{2, 2, 0, 24'hA0A0A0});
        tbl.push_back('{2, 5, 1, 24'h787878});
        tbl.push_back('{2, 0, 2, 24'h282828});
        tbl.push_back('{2, 7, 2, 24'h282828});
        tbl.push_back('{2, 4, 3, 24'h000000});
        tbl.push_back('{3, 4, 4, 24'hFF0000});
        tbl.push_back('{3, 5, 5, 24'h000000});
        tbl.push_back('{4, 5, 5, 24'h400000});
        tbl.push_back('{4, 4, 4, 24'h100000});
        tbl.push_back('{5, 8, 3, 24'hA0A0A0});
        tbl.push_back('{5, 9, 3, 24'hB4B4B4});
        tbl.push_back('{5, 7, 3, 24'h787878});
        tbl.push_back('{5, 1, 2, 24'h050505});
        tbl.push_back('{5, 4, 5, 24'h3C3C3C});

        repeat (3) tick();
        check("reset vs_o", PW'(vs_o), '0);
        check("reset de_o", PW'(de_o), '0);
        check("reset rgb_o", rgb_o, '0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk_en = 1'b1;

        cur = -1;
        foreach (tbl[i]) begin
            if (tbl[i].frame != cur) begin
                cur = tbl[i].frame;
                run_frame(cur);
            end
            check($sformatf("spot frame%0d x%0d y%0d", tbl[i].frame, tbl[i].x, tbl[i].y),
                  out_img[tbl[i].y][tbl[i].x], tbl[i].exp);
        end

        // Asynchronous reset in the middle of a line.
        chk_en = 1'b0;
        filter_en = 1'b1;
        vs_i = 1'b1; tick(); tick();
        vs_i = 1'b0; tick();
        de_i = 1'b1; rgb_i = 24'h123456;
        repeat (6) tick();
        check("de_o before reset", PW'(de_o), PW'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async reset vs_o", PW'(vs_o), '0);
        check("async reset de_o", PW'(de_o), '0);
        check("async reset rgb_o", rgb_o, '0);
        de_i = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk_en = 1'b1;
        run_frame(0);
        check("post-reset flat x3 y3", out_img[3][3], 24'h808080);
        run_frame(1);
        check("post-reset impulse x5 y5", out_img[5][5], 24'h400000);
        check("post-reset impulse x4 y5", out_img[5][4], 24'h200000);

        // Random frames, including vs_i rising together with the first pixel.
        for (int f = 0; f < 6; f++) begin
            int w, h;
            w = $urandom_range(3, 10);
            h = $urandom_range(2, 7);
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++)
                    img[y][x] = PW'($urandom);
            drive_frame(w, h, 1'($urandom_range(0, 1)) | (f < 2), -1, 1'b0, (f % 2) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
